// File: rtl/wb_arbiter_2m.sv
// Two-master round-robin Wishbone arbiter with bus locking for the whole cyc,
// plus a per-transfer watchdog that acks hung strobes with TO_DATA.
module wb_arbiter_2m #(
  parameter int              AW      = 32,
  parameter int              DW      = 32,
  parameter int              TIMEOUT = 255,
  parameter logic [DW-1:0]   TO_DATA = DW'(32'hDEAD_BEEF)
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,

  input  logic              m0_cyc_i,
  input  logic              m0_stb_i,
  input  logic              m0_we_i,
  input  logic [DW/8-1:0]   m0_sel_i,
  input  logic [AW-1:0]     m0_adr_i,
  input  logic [DW-1:0]     m0_dat_i,
  output logic              m0_ack_o,
  output logic [DW-1:0]     m0_dat_o,

  input  logic              m1_cyc_i,
  input  logic              m1_stb_i,
  input  logic              m1_we_i,
  input  logic [DW/8-1:0]   m1_sel_i,
  input  logic [AW-1:0]     m1_adr_i,
  input  logic [DW-1:0]     m1_dat_i,
  output logic              m1_ack_o,
  output logic [DW-1:0]     m1_dat_o,

  output logic              s_cyc_o,
  output logic              s_stb_o,
  output logic              s_we_o,
  output logic [DW/8-1:0]   s_sel_o,
  output logic [AW-1:0]     s_adr_o,
  output logic [DW-1:0]     s_dat_o,
  input  logic              s_ack_i,
  input  logic [DW-1:0]     s_dat_i,

  output logic [1:0]        grant_o,
  output logic              timeout_o
);

  localparam int            CW     = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] TO_MAX = CW'(TIMEOUT);

  // State encoding doubles as the one-hot grant vector.
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    G0   = 2'b01,
    G1   = 2'b10
  } state_t;

  state_t          state;
  logic            last;
  logic [CW-1:0]   wd_cnt;

  logic            own_cyc;
  logic            own_stb;
  logic            own_we;
  logic [DW/8-1:0] own_sel;
  logic [AW-1:0]   own_adr;
  logic [DW-1:0]   own_dat;
  logic            fire;
  logic            resp_ack;
  logic [DW-1:0]   resp_dat;

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    own_cyc = 1'b0;
    own_stb = 1'b0;
    own_we  = 1'b0;
    own_sel = '0;
    own_adr = '0;
    own_dat = '0;
    case (state)
      G0: begin
        own_cyc = m0_cyc_i;
        own_stb = m0_stb_i;
        own_we  = m0_we_i;
        own_sel = m0_sel_i;
        own_adr = m0_adr_i;
        own_dat = m0_dat_i;
      end
      G1: begin
        own_cyc = m1_cyc_i;
        own_stb = m1_stb_i;
        own_we  = m1_we_i;
        own_sel = m1_sel_i;
        own_adr = m1_adr_i;
        own_dat = m1_dat_i;
      end
      default: ;
    endcase
  end

  // The counter only reaches TO_MAX while the owner is stalled, so fire is a single cycle.
  assign fire     = own_cyc && own_stb && (wd_cnt == TO_MAX);

  assign s_cyc_o  = own_cyc && !fire;
  assign s_stb_o  = own_cyc && own_stb && !fire;
  assign s_we_o   = own_we;
  assign s_sel_o  = own_sel;
  assign s_adr_o  = own_adr;
  assign s_dat_o  = own_dat;

  // A timeout overrides a coincident slave ack.
  assign resp_ack = fire || s_ack_i;
  assign resp_dat = fire ? TO_DATA : s_dat_i;

  assign m0_ack_o  = (state == G0) && resp_ack;
  assign m1_ack_o  = (state == G1) && resp_ack;
  assign m0_dat_o  = (state == G0) ? resp_dat : '0;
  assign m1_dat_o  = (state == G1) ? resp_dat : '0;
  assign grant_o   = state;
  assign timeout_o = fire;

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state  <= IDLE;
      last   <= 1'b1;
      wd_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (m0_cyc_i && (!m1_cyc_i || last)) begin
            state <= G0;
            last  <= 1'b0;
          end else if (m1_cyc_i) begin
            state <= G1;
            last  <= 1'b1;
          end
        end
        G0:      if (!m0_cyc_i) state <= IDLE;
        G1:      if (!m1_cyc_i) state <= IDLE;
        default: state <= IDLE;
      endcase

      // s_stb_o is low in IDLE, on a dropped strobe and on the firing cycle.
      if (!s_stb_o || s_ack_i)
        wd_cnt <= '0;
      else
        wd_cnt <= wd_cnt + CW'(1);
    end
  end

endmodule

// File: doc/wb_arbiter_2m.md
# wb_arbiter_2m

Two-master Wishbone arbiter that shares the single Wishbone slave port of `user_proj_example` between the management SoC (`wbs_*` from the wrapper) and a second on-chip master, such as a logic-analyzer-driven debug master. It uses round-robin arbitration with bus locking for the duration of `cyc`. A per-transfer watchdog terminates hung accesses so that neither master can stall forever. It sits inside `user_project_wrapper`, between the top-level Wishbone pins plus the second master and the `mprj` slave port.

## Interface
Parameters:
- `AW`, 32, address width.
- `DW`, 32, data width; `sel` width is `DW/8`.
- `TIMEOUT`, 255, number of consecutive stalled strobe cycles before the watchdog fires; must be at least 2.
- `TO_DATA`, 32'hDEAD_BEEF, read data returned on a timeout.

Ports:
- `wb_clk_i` in 1: the single clock.
- `wb_rst_i` in 1: asynchronous, active-high reset.
- `m0_cyc_i`, `m0_stb_i`, `m0_we_i` in 1 each: master 0 (management SoC) control.
- `m0_sel_i` in DW/8; `m0_adr_i` in AW; `m0_dat_i` in DW: master 0 request.
- `m0_ack_o` out 1; `m0_dat_o` out DW: master 0 response.
- `m1_*`: identical set of ports for master 1.
- `s_cyc_o`, `s_stb_o`, `s_we_o` out 1; `s_sel_o` out DW/8; `s_adr_o` out AW; `s_dat_o` out DW: outputs to the slave.
- `s_ack_i` in 1; `s_dat_i` in DW: slave response.
- `grant_o` out 2: one-hot current owner; 2'b00 means idle.
- `timeout_o` out 1: one-cycle pulse when the watchdog fires.

## Operation
State machine states:
- **IDLE**: the grant register is 00 and all `s_*` outputs are 0.
- **G0**: master 0 owns the bus.
- **G1**: master 1 owns the bus.

Transitions out of IDLE:
- Only `m0_cyc_i` is high: go to G0.
- Only `m1_cyc_i` is high: go to G1.
- Both are high: grant the master that was *not* served last (`last` register).
- On entering Gx, set `last` to x.

Transitions out of Gx:
- Remain in Gx while `mx_cyc_i` stays high. This bus lock covers multi-beat and read-modify-write cycles.
- When `mx_cyc_i` falls, go to IDLE.
- No direct G0→G1 handoff is allowed; there is always one IDLE cycle between owners.

Signal routing while in Gx:
- `s_*` outputs are driven combinationally from master x's inputs.
- `mx_ack_o` = `s_ack_i`.
- `mx_dat_o` = `s_dat_i`.
- The other master sees ack = 0 and dat = 0.

Watchdog:
- A counter of width `$clog2(TIMEOUT+1)` increments on every cycle in which `s_stb_o` = 1 and `s_ack_i` = 0.
- The counter clears on `s_ack_i`, on leaving Gx, or when the master drops `stb`.
- When the counter equals `TIMEOUT`, the arbiter does all of the following in the same cycle:
  - forces `s_stb_o` and `s_cyc_o` to 0;
  - asserts `mx_ack_o` = 1 with `mx_dat_o` = `TO_DATA`;
  - pulses `timeout_o`;
  - clears the counter.
- The grant is held for as long as `mx_cyc_i` remains high.
- An `s_ack_i` arriving in the same cycle as the timeout loses: the master sees `TO_DATA`.

Boundary behaviour:
- Any assertion of `wb_rst_i` immediately forces IDLE, `grant_o` = 0, `last` = 1 (so master 0 wins the first tie), counter = 0, and `timeout_o` = 0.
- An in-flight transfer is dropped on reset and no ack is issued.
- A master asserting `stb` without `cyc` is ignored.

## Timing
- All outputs reset to 0.
- Grant latency: a `cyc` that rises in cycle N while IDLE produces `grant_o` and `s_cyc_o`/`s_stb_o` in cycle N+1. A request that arrives during another master's ownership waits until release + 1 cycle.
- Response path is combinational with zero added latency: slave ack in cycle K appears at the master in cycle K.
- Watchdog: with `stb` first seen at the slave in cycle S and no ack, the timeout ack occurs in cycle S+TIMEOUT.
- `grant_o` changes only on clock edges (or asynchronously on reset).

## Test plan
1. Single master 0 read: the slave acks 2 cycles after `stb` with 0x1234_5678. Required: `grant_o` = 01 one cycle after `cyc`, `m0_dat_o` = 0x1234_5678 with ack, `m1_ack_o` stays 0, and IDLE is reached one cycle after `cyc` drops.
2. Simultaneous requests right after reset: both `cyc` rise together. Required: master 0 is served first; on release, one IDLE cycle, then `grant_o` = 10. Repeat the tie: master 0 wins again, since `last` = 1 after master 1 was served.
3. Locked RMW: master 1 holds `cyc` across a read beat and a write beat while master 0 requests. Required: master 0 stays ungranted until master 1 drops `cyc`, then is granted 2 cycles later.
4. Timeout: `TIMEOUT` = 8, slave never acks a master 0 read. Required: in cycle S+8, `m0_ack_o` = 1, `m0_dat_o` = 0xDEAD_BEEF, `timeout_o` is a 1-cycle pulse, and `s_stb_o` = 0. A late `s_ack_i` in cycle S+8 is ignored.
5. Reset mid-transfer: assert `wb_rst_i` while in G1 with `stb` high. Required: `s_cyc_o`, `s_stb_o`, `grant_o` and all acks go to 0 immediately (before the next edge); after release, a tie grants master 0.
6. `stb` without `cyc` on master 1 for 10 cycles. Required: `grant_o` stays 00 and no slave strobe is issued.
